// File: rtl/neuron_core_wb_initiator.sv
// Wishbone classic initiator for the neuron core slave port: one single read or
// write per region/index command, returning read data or an error flag.
module neuron_core_wb_initiator #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [1:0]  cmd_region,
    input  logic [10:0] cmd_index,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [14:0]   enc_off;

    // Core address map: region in [14:13]; params are 16-byte strided, words 4-byte.
    always_comb begin
        enc_off = '0;
        case (cmd_region)
            2'b00:   enc_off = {2'b00, cmd_index, 2'b00};
            2'b01:   enc_off = {2'b01, 4'b0000, cmd_index[4:0], 4'b0000};
            2'b10:   enc_off = {2'b10, cmd_index, 2'b00};
            default: enc_off = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cnt_d = '0;
                    if (cmd_region == 2'b11) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = BUS;
                        cyc_d   = 1'b1;
                        we_d    = cmd_we;
                        sel_d   = 4'hF;
                        adr_d   = BASE_ADDR | {17'b0, enc_off};
                        dat_d   = cmd_we ? cmd_wdata : '0;
                    end
                end
            end
            BUS: begin
                // An ack arriving in the expiry cycle still completes normally.
                if (wbm_ack_i || (cnt_q == CNT_LAST)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                    adr_d   = '0;
                    dat_d   = '0;
                    err_d   = ~wbm_ack_i;
                    rdata_d = (wbm_ack_i && !we_q) ? wbm_dat_i : '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                err_d   = 1'b0;
                rdata_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_neuron_core_wb_initiator.sv
// Directed bench for neuron_core_wb_initiator: a transaction-level model predicts
// every bus and response cycle from accept time, ack delay and the address map.
module tb_neuron_core_wb_initiator;

    localparam logic [31:0] BASE    = 32'h3000_0000;
    localparam int          TIMEOUT = 16;

    logic        wb_clk_i, wb_rst_i;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [1:0]  cmd_region;
    logic [10:0] cmd_index;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

    neuron_core_wb_initiator #(.BASE_ADDR(BASE), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_region(cmd_region), .cmd_index(cmd_index), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    typedef struct {
        int          acc;    // cycle number of the accepting edge
        int          s;      // number of strobe cycles
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] rdata;
        logic        err;
    } txn_t;

    txn_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc_no = 0;
    int          ack_delay = -1;
    int          slv_cnt = 0;
    logic [31:0] slave_data = 32'h0;
    logic        stray_ack = 1'b0;

    initial begin
        wb_clk_i = 1'b0;
        forever #5 wb_clk_i = ~wb_clk_i;
    end

    initial forever begin
        @(posedge wb_clk_i);
        cyc_no++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_no);
        end
    endtask

    // Slave: acks the strobe after ack_delay wait cycles (-1 = never).
    initial begin
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'hBAD0_BAD0;
        forever begin
            @(negedge wb_clk_i);
            if (wbm_stb_o) begin
                wbm_ack_i = (slv_cnt == ack_delay);
                wbm_dat_i = (slv_cnt == ack_delay) ? slave_data : 32'hBAD0_BAD0;
                slv_cnt++;
            end else begin
                wbm_ack_i = stray_ack;
                wbm_dat_i = 32'hBAD0_BAD0;
                slv_cnt   = 0;
            end
        end
    end

    // Per-cycle comparison against the transaction model.
    initial begin
        txn_t t;
        logic ec, er, eb;
        forever begin
            @(negedge wb_clk_i);
            #1;
            if (!wb_rst_i) begin
                ec = 1'b0; er = 1'b0; eb = 1'b0;
                if (q.size() > 0) begin
                    t  = q[0];
                    ec = (t.s > 0) && (cyc_no >= t.acc) && (cyc_no < t.acc + t.s);
                    er = (cyc_no == t.acc + t.s);
                    eb = (cyc_no >= t.acc) && (cyc_no <= t.acc + t.s);
                end
                chk("cyc", wbm_cyc_o, ec);
                chk("stb", wbm_stb_o, ec);
                chk("sel", wbm_sel_o, ec ? 4'hF : 4'h0);
                chk("adr", wbm_adr_o, ec ? t.adr : 32'h0);
                if (ec) begin
                    chk("we", wbm_we_o, t.we);
                    chk("dat_o", wbm_dat_o, t.dat);
                end
                chk("busy", busy, eb);
                chk("cmd_ready", cmd_ready, !eb);
                chk("rsp_valid", rsp_valid, er);
                if (er) begin
                    chk("rsp_rdata", rsp_rdata, t.rdata);
                    chk("rsp_err", rsp_err, t.err);
                    void'(q.pop_front());
                end
            end
        end
    end

    // Present a command (called at a negedge); returns at the negedge after accept.
    task automatic send(input logic we, input logic [1:0] rgn, input logic [10:0] idx,
                        input logic [31:0] wd, output int acc);
        txn_t t;
        int   n;
        cmd_we = we; cmd_region = rgn; cmd_index = idx; cmd_wdata = wd; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge wb_clk_i);
            n++;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL accept: cmd_ready never seen, got 0 expected 1");
            cmd_valid = 1'b0;
            acc = -1;
        end else begin
            acc     = cyc_no + 1;
            t.acc   = acc;
            t.we    = we;
            t.adr   = BASE | (32'(rgn) << 13) |
                      ((rgn == 2'b01) ? (32'(idx[4:0]) << 4) : (32'(idx) << 2));
            t.dat   = we ? wd : 32'h0;
            if (rgn == 2'b11) begin
                t.s = 0; t.err = 1'b1; t.rdata = 32'h0;
            end else if (ack_delay >= 0 && ack_delay < TIMEOUT) begin
                t.s = ack_delay + 1; t.err = 1'b0; t.rdata = we ? 32'h0 : slave_data;
            end else begin
                t.s = TIMEOUT; t.err = 1'b1; t.rdata = 32'h0;
            end
            q.push_back(t);
            @(negedge wb_clk_i);
        end
    endtask

    task automatic wait_stb(input string nm);
        int n = 0;
        while (!wbm_stb_o && n < 40) begin
            @(negedge wb_clk_i);
            n++;
        end
        checks++;
        if (!wbm_stb_o) begin
            errors++;
            $display("FAIL %s: stb got 0 expected 1", nm);
        end
    endtask

    task automatic wait_rsp(output logic [31:0] rd, output logic e, output int at);
        int n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge wb_clk_i);
            n++;
        end
        checks++;
        if (!rsp_valid) begin
            errors++;
            $display("FAIL rsp_wait: rsp_valid got 0 expected 1");
            rd = 32'hX; e = 1'bX; at = -1;
        end else begin
            rd = rsp_rdata; e = rsp_err; at = cyc_no;
            @(negedge wb_clk_i);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time got 100000 expected less");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          a, r, a4, b0, b1, b2;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_region = 2'b00; cmd_index = '0; cmd_wdata = '0;
        wb_rst_i  = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        #1;
        chk("rst_cyc", wbm_cyc_o, 1'b0);
        chk("rst_adr", wbm_adr_o, 32'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(negedge wb_clk_i);
        #2 wb_rst_i = 1'b0;
        @(negedge wb_clk_i);

        // 1: write region 00, index 7FF, one wait cycle
        ack_delay = 1;
        send(1'b1, 2'b00, 11'h7FF, 32'hDEADBEEF, a);
        cmd_valid = 1'b0;
        wait_stb("t1_stb");
        chk("t1_adr", wbm_adr_o, 32'h3000_1FFC);
        chk("t1_we", wbm_we_o, 1'b1);
        chk("t1_sel", wbm_sel_o, 4'hF);
        chk("t1_dat", wbm_dat_o, 32'hDEADBEEF);
        wait_rsp(rd, e, r);
        chk("t1_err", e, 1'b0);
        chk("t1_lat", r - a, 2);

        // 2: read region 01, index 7F3, zero-wait slave returns A5
        ack_delay = 0; slave_data = 32'h0000_00A5;
        send(1'b0, 2'b01, 11'h7F3, 32'hFFFF_FFFF, a);
        cmd_valid = 1'b0;
        wait_stb("t2_stb");
        chk("t2_adr", wbm_adr_o, 32'h3000_2130);
        chk("t2_dat", wbm_dat_o, 32'h0);
        wait_rsp(rd, e, r);
        chk("t2_rdata", rd, 32'h0000_00A5);
        chk("t2_err", e, 1'b0);

        // 3: read region 10 with no ack -> timeout; 4: region 11 right after
        ack_delay = -1;
        send(1'b0, 2'b10, 11'd3, 32'h0, a);
        cmd_valid = 1'b0;
        wait_stb("t3_stb");
        chk("t3_adr", wbm_adr_o, 32'h3000_400C);
        wait_rsp(rd, e, r);
        chk("t3_err", e, 1'b1);
        chk("t3_rdata", rd, 32'h0);
        chk("t3_lat", r - a, 16);
        send(1'b1, 2'b11, 11'h155, 32'h5555_5555, a4);
        cmd_valid = 1'b0;
        chk("t3_next_accept", a4 - r, 2);
        wait_rsp(rd, e, r);
        chk("t4_err", e, 1'b1);
        chk("t4_rdata", rd, 32'h0);
        chk("t4_lat", r - a4, 0);

        // 5: async reset mid-BUS, then a stray ack in IDLE
        ack_delay = -1;
        send(1'b0, 2'b00, 11'd5, 32'h0, a);
        cmd_valid = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        #2 wb_rst_i = 1'b1;
        q.delete();
        #1;
        chk("t5_cyc", wbm_cyc_o, 1'b0);
        chk("t5_stb", wbm_stb_o, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_rsp_valid", rsp_valid, 1'b0);
        @(negedge wb_clk_i);
        #2 wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        #2 stray_ack = 1'b1;
        @(negedge wb_clk_i);
        #2 stray_ack = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        chk("t5_idle_busy", busy, 1'b0);
        chk("t5_idle_ready", cmd_ready, 1'b1);

        // 6: ack in the expiry cycle, then back-to-back with held cmd_valid
        ack_delay = TIMEOUT - 1; slave_data = 32'h1234_5678;
        send(1'b0, 2'b10, 11'h400, 32'h0, a);
        cmd_valid = 1'b0;
        wait_rsp(rd, e, r);
        chk("t6_err", e, 1'b0);
        chk("t6_rdata", rd, 32'h1234_5678);
        chk("t6_lat", r - a, 16);
        ack_delay = 0; slave_data = 32'h0BAD_CAFE;
        send(1'b1, 2'b00, 11'd1, 32'h0000_0011, b0);
        send(1'b1, 2'b10, 11'd2, 32'h0000_0022, b1);
        send(1'b0, 2'b01, 11'd3, 32'h0, b2);
        cmd_valid = 1'b0;
        chk("t6_gap1", b1 - b0, 3);
        chk("t6_gap2", b2 - b1, 3);
        repeat (6) @(negedge wb_clk_i);
        chk("pending", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
